// File: rtl/im_fetch_sequencer_pkg.sv
// Shared encodings and widths for the IM fetch path; reused by datapath control and loader.
package im_fetch_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam int ADDR_W_DEF   = 32;
    localparam int IM_DEPTH_DEF = 256;
    localparam int INST_W       = 32;

endpackage

// File: rtl/im_fetch_sequencer_pc_reg.sv
// PC register with next-pc selection: reset load, redirect, +1 step, hold.
module im_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_reset_i,
    input  logic              advance_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] issue_addr_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // A redirect target is issued in the redirect cycle itself, so the
    // register then moves on to target+1 and only one bubble is seen.
    assign issue_addr_o = redirect_i ? redirect_pc_i : pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_reset_i) begin
            pc_d = RESET_PC;
        end else if (advance_i) begin
            pc_d = issue_addr_o + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/im_fetch_sequencer.sv
// Owns the IM port: loader writes, instruction fetch reads, PC sequencing.
//  state | meaning
//  IDLE  | waiting for a loader word or run
//  LOAD  | accepting loader writes until load_done
//  RUN   | fetching one word per cycle, presenting inst/pc pairs
//  HALT  | fetch stopped (halt_req or fault), PC frozen until run drops
module im_fetch_sequencer
    import im_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                IM_DEPTH = IM_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [INST_W-1:0] load_data_i,
    input  logic              load_done_i,
    input  logic              run_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_req_i,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic              im_we_o,
    output logic [INST_W-1:0] im_wdata_o,
    input  logic [INST_W-1:0] im_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic [1:0]        state_o,
    output logic              fault_o
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(IM_DEPTH);

    state_t            state_q, state_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fault_q, fault_d;

    logic              pc_load_reset;
    logic              pc_advance;
    logic              pc_redirect;
    logic [ADDR_W-1:0] issue_addr;
    logic              stall_hold;
    logic              issue_oob;
    logic              load_in_range;
    logic              im_we_c;
    logic [ADDR_W-1:0] im_addr_c;
    logic [INST_W-1:0] im_wdata_c;

    assign pc_redirect   = (state_q == ST_RUN) && redirect_valid_i;
    assign stall_hold    = stall_i && !redirect_valid_i;
    assign issue_oob     = issue_addr >= DEPTH_A;
    assign load_in_range = load_addr_i < DEPTH_A;

    im_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .load_reset_i  (pc_load_reset),
        .advance_i     (pc_advance),
        .redirect_i    (pc_redirect),
        .redirect_pc_i (redirect_pc_i),
        .issue_addr_o  (issue_addr)
    );

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        fault_d       = fault_q;
        pc_load_reset = 1'b0;
        pc_advance    = 1'b0;
        im_we_c       = 1'b0;
        im_addr_c     = '0;
        im_wdata_c    = '0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid_i) begin
                    state_d = ST_LOAD;
                end else if (run_i) begin
                    state_d       = ST_RUN;
                    pc_load_reset = 1'b1;
                    fetch_valid_d = 1'b0;
                    inst_valid_d  = 1'b0;
                end
            end

            ST_LOAD: begin
                if (load_valid_i) begin
                    im_addr_c  = load_addr_i;
                    im_wdata_c = load_data_i;
                    if (load_in_range) begin
                        im_we_c = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                if (load_done_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // While stalled, keep re-reading the word already in flight so
                // its data is still on im_rdata when the stall releases.
                im_addr_c = (stall_hold && fetch_valid_q) ? fetch_pc_q : issue_addr;
                if (halt_req_i) begin
                    state_d       = ST_HALT;
                    inst_valid_d  = 1'b0;
                    fetch_valid_d = 1'b0;
                end else if (!run_i) begin
                    state_d       = ST_IDLE;
                    inst_valid_d  = 1'b0;
                    fetch_valid_d = 1'b0;
                end else if (!stall_hold) begin
                    if (issue_oob) begin
                        fault_d       = 1'b1;
                        state_d       = ST_HALT;
                        inst_valid_d  = 1'b0;
                        fetch_valid_d = 1'b0;
                    end else begin
                        pc_advance    = 1'b1;
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = issue_addr;
                        inst_d        = im_rdata_i;
                        inst_pc_d     = fetch_pc_q;
                        inst_valid_d  = fetch_valid_q && !redirect_valid_i;
                    end
                end
            end

            default: begin
                inst_valid_d  = 1'b0;
                fetch_valid_d = 1'b0;
                if (!run_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            inst_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign load_ready_o = (state_q == ST_LOAD);
    assign im_we_o      = im_we_c && rst_n_i;
    assign im_addr_o    = im_addr_c;
    assign im_wdata_o   = im_wdata_c;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
    assign state_o      = state_q;
    assign fault_o      = fault_q;

endmodule
